// File: rtl/vscale_mul_div_param_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Op and output-select encodings match the rest of the vscale pipeline.
package vscale_mul_div_param_pkg;

  localparam int MD_OP_WIDTH = 2;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

  localparam int MD_OUT_SEL_WIDTH = 2;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = 2'd0;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = 2'd1;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SETUP   = 2'd2,
    ST_DONE    = 2'd3
  } md_state_e;

endpackage

// File: rtl/vscale_mul_div_param_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface vscale_mul_div_param_if
  import vscale_mul_div_param_pkg::*;
#(
  parameter int XLEN = 32
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_in_1_signed;
  logic                        req_in_2_signed;
  logic [MD_OP_WIDTH-1:0]      req_op;
  logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel;
  logic [XLEN-1:0]             req_in_1;
  logic [XLEN-1:0]             req_in_2;
  logic                        kill;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [XLEN-1:0]             resp_result;

  modport master (
    output req_valid, req_in_1_signed, req_in_2_signed, req_op, req_out_sel,
           req_in_1, req_in_2, kill, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_in_1_signed, req_in_2_signed, req_op, req_out_sel,
           req_in_1, req_in_2, kill, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/vscale_md_mul_step.sv
// One multiply iteration: shift the accumulator up by MUL_BITS and add b times the
// next MUL_BITS multiplier bits (MSB first). Purely combinational.
module vscale_md_mul_step #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic [2*XLEN-1:0]  i_acc,
  input  logic [XLEN-1:0]    i_b,
  input  logic [MUL_BITS-1:0] i_bits,
  output logic [2*XLEN-1:0]  o_acc
);

  logic [XLEN+MUL_BITS-1:0] w_partial;

  always_comb begin
    w_partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (i_bits[i]) begin
        w_partial = w_partial + ({{MUL_BITS{1'b0}}, i_b} << i);
      end
    end
    o_acc = (i_acc << MUL_BITS) + {{(XLEN-MUL_BITS){1'b0}}, w_partial};
  end

endmodule

// File: rtl/vscale_mul_div_param.sv
// Iterative RV M-extension multiply/divide unit: radix-2^MUL_BITS multiply, restoring divide,
// single-cycle bypass for divide-by-zero and signed overflow, with kill and response backpressure.
module vscale_mul_div_param
  import vscale_mul_div_param_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  vscale_mul_div_param_if.slave md
);

  localparam int CW = $clog2(XLEN);

  md_state_e                   r_state, w_next;
  logic [2*XLEN-1:0]           r_a, r_b;
  logic [XLEN-1:0]             r_m;
  logic [XLEN-1:0]             r_result, r_special_res;
  logic [CW-1:0]               r_cnt;
  logic                        r_negate, r_special;
  logic [MD_OP_WIDTH-1:0]      r_op;
  logic [MD_OUT_SEL_WIDTH-1:0] r_out_sel;

  logic              w_sign1, w_sign2, w_is_mul, w_div_zero, w_overflow, w_special;
  logic              w_accept, w_div_ge;
  logic [XLEN-1:0]   w_abs1, w_abs2, w_special_res, w_quo, w_rem, w_out;
  logic [2*XLEN-1:0] w_mul_acc, w_prod;

  // Magnitudes and the special-case decision are taken from the live request.
  assign w_sign1    = md.req_in_1_signed & md.req_in_1[XLEN-1];
  assign w_sign2    = md.req_in_2_signed & md.req_in_2[XLEN-1];
  assign w_abs1     = w_sign1 ? -md.req_in_1 : md.req_in_1;
  assign w_abs2     = w_sign2 ? -md.req_in_2 : md.req_in_2;
  assign w_is_mul   = (md.req_op == MD_OP_MUL);
  assign w_div_zero = !w_is_mul && (md.req_in_2 == '0);
  assign w_overflow = !w_is_mul && md.req_in_1_signed && md.req_in_2_signed &&
                      (md.req_in_1 == {1'b1, {(XLEN-1){1'b0}}}) && (md.req_in_2 == '1);
  assign w_special  = w_div_zero | w_overflow;
  assign w_accept   = md.req_valid && (r_state == ST_IDLE) && !md.kill;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = (md.req_out_sel == MD_OUT_REM) ? md.req_in_1 : '1;
    end else begin
      w_special_res = (md.req_out_sel == MD_OUT_REM) ? '0 : md.req_in_1;
    end
  end

  vscale_md_mul_step #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_mul_step (
    .i_acc  (r_a),
    .i_b    (r_b[XLEN-1:0]),
    .i_bits (r_m[XLEN-1 -: MUL_BITS]),
    .o_acc  (w_mul_acc)
  );

  assign w_div_ge = (r_a >= r_b);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = w_special ? ST_SETUP : ST_COMPUTE;
      ST_COMPUTE: if (r_cnt == '0) w_next = ST_SETUP;
      ST_SETUP:   w_next = ST_DONE;
      ST_DONE:    if (md.resp_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (md.kill && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Result selection: the product is negated at full width so HI sees the borrow from LO.
  assign w_prod = r_negate ? -r_a : r_a;
  assign w_quo  = r_negate ? -r_m : r_m;
  assign w_rem  = r_negate ? -r_a[XLEN-1:0] : r_a[XLEN-1:0];

  always_comb begin
    w_out = '0;
    if (r_special) begin
      w_out = r_special_res;
    end else begin
      case (r_out_sel)
        MD_OUT_LO: w_out = (r_op == MD_OP_MUL) ? w_prod[XLEN-1:0] : w_quo;
        MD_OUT_HI: w_out = w_prod[2*XLEN-1:XLEN];
        default:   w_out = w_rem;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a           <= '0;
      r_b           <= '0;
      r_m           <= '0;
      r_cnt         <= '0;
      r_negate      <= 1'b0;
      r_special     <= 1'b0;
      r_special_res <= '0;
      r_op          <= MD_OP_MUL;
      r_out_sel     <= MD_OUT_LO;
      r_result      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op          <= md.req_op;
            r_out_sel     <= md.req_out_sel;
            r_negate      <= (md.req_op == MD_OP_REM) ? w_sign1 : (w_sign1 ^ w_sign2);
            r_special     <= w_special;
            r_special_res <= w_special_res;
            r_m           <= w_abs2;
            if (w_is_mul) begin
              r_a   <= '0;
              r_b   <= {{XLEN{1'b0}}, w_abs1};
              r_cnt <= CW'(XLEN - MUL_BITS);
            end else begin
              r_a   <= {{XLEN{1'b0}}, w_abs1};
              r_b   <= {w_abs2, {XLEN{1'b0}}} >> 1;
              r_cnt <= CW'(XLEN - 1);
            end
          end
        end
        ST_COMPUTE: begin
          if (r_op == MD_OP_MUL) begin
            r_a   <= w_mul_acc;
            r_m   <= r_m << MUL_BITS;
            r_cnt <= r_cnt - CW'(MUL_BITS);
          end else begin
            r_a   <= w_div_ge ? (r_a - r_b) : r_a;
            r_b   <= r_b >> 1;
            r_m   <= {r_m[XLEN-2:0], w_div_ge};
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SETUP: r_result <= w_out;
        default: ;
      endcase
    end
  end

  assign md.req_ready   = (r_state == ST_IDLE);
  assign md.resp_valid  = (r_state == ST_DONE);
  assign md.resp_result = r_result;

endmodule
